// File: rtl/mainfsm_pkg.sv
// mainfsm_pkg: shared constants and types for the multi-cycle MIPS controller.
//   - Opcode constants (instr[31:26]) decoded by the main control FSM.
//   - Funct constants used by the ALU decoder for R-type instructions.
//   - statetype_t: 4-bit state encoding of mainfsm, exported so that
//     debug logic and testbenches can decode the `state` output.
package mainfsm_pkg;

  // Opcodes
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Funct codes (R-type)
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // Main FSM states; encodings 12..15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } statetype_t;

endpackage

// File: rtl/mainfsm.sv
// mainfsm: main control state machine of the multi-cycle MIPS core.
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives the datapath selects and write enables (Moore outputs).
// Ports:
//   clk        - core clock, rising edge
//   rst_n      - synchronous active-low reset
//   op         - opcode, instr[31:26]
//   memtoreg, regdst, iord, pcsrc[1:0], alusrcb[1:0], alusrca - mux selects
//   irwrite, memwrite, pcwrite, branch, regwrite - write enables
//   aluop[1:0] - ALU decoder control (00 add, 01 sub, 10 funct)
//   illegal_op - one-cycle pulse in DECODE for an unsupported opcode
//   state[3:0] - current state encoding (debug)
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic [1:0] pcsrc,
  output logic [1:0] alusrcb,
  output logic       alusrca,
  output logic       irwrite,
  output logic       memwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       regwrite,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic [3:0] state
);

  statetype_t cur_state, nxt_state;

  // Ungated versions of the write-type outputs.
  logic irwrite_s, memwrite_s, pcwrite_s, branch_s, regwrite_s, illegal_s;

  always_ff @(posedge clk) begin
    if (!rst_n) cur_state <= FETCH;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state  = FETCH;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    iord       = 1'b0;
    pcsrc      = 2'b00;
    alusrcb    = 2'b00;
    alusrca    = 1'b0;
    aluop      = 2'b00;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    regwrite_s = 1'b0;
    illegal_s  = 1'b0;
    case (cur_state)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
        nxt_state = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed here as PC+4 + (signimm<<2).
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_RTYPE:     nxt_state = EXECUTE;
          OP_BEQ:       nxt_state = BRANCH;
          OP_ADDI:      nxt_state = ADDIEXEC;
          OP_J:         nxt_state = JUMP;
          default: begin
            nxt_state = FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        // Only LW and SW reach this state; anything but SW is treated as LW.
        nxt_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        iord      = 1'b1;
        nxt_state = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWRITE: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTE: begin
        alusrca   = 1'b1;
        aluop     = 2'b10;
        nxt_state = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch_s = 1'b1;
      end
      ADDIEXEC: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        nxt_state = ADDIWB;
      end
      ADDIWB: begin
        regwrite_s = 1'b1;
      end
      JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_s = 1'b1;
      end
      default: nxt_state = FETCH;
    endcase
  end

  // Write enables are masked during reset so no architectural state moves
  // while rst_n is low, regardless of which state the register holds.
  assign irwrite    = irwrite_s  & rst_n;
  assign memwrite   = memwrite_s & rst_n;
  assign pcwrite    = pcwrite_s  & rst_n;
  assign branch     = branch_s   & rst_n;
  assign regwrite   = regwrite_s & rst_n;
  assign illegal_op = illegal_s  & rst_n;
  assign state      = cur_state;

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: self-checking bench for mainfsm. A behavioural model tracks
// the position within each instruction's state sequence and the expected
// outputs per state; a compare process checks every cycle, and directed
// instructions pin the model with literal traces and output vectors.
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       memtoreg, regdst, iord, alusrca, irwrite, memwrite;
  logic       pcwrite, branch, regwrite, illegal_op;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic [3:0] state;

  mainfsm dut (
    .clk(clk), .rst_n(rst_n), .op(op),
    .memtoreg(memtoreg), .regdst(regdst), .iord(iord), .pcsrc(pcsrc),
    .alusrcb(alusrcb), .alusrca(alusrca), .irwrite(irwrite),
    .memwrite(memwrite), .pcwrite(pcwrite), .branch(branch),
    .regwrite(regwrite), .aluop(aluop), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Output vector layout:
  // [15]memtoreg [14]regdst [13]iord [12:11]pcsrc [10:9]alusrcb [8]alusrca
  // [7]irwrite [6]memwrite [5]pcwrite [4]branch [3]regwrite [2:1]aluop [0]illegal
  logic [15:0] act_vec;
  assign act_vec = {memtoreg, regdst, iord, pcsrc, alusrcb, alusrca, irwrite,
                    memwrite, pcwrite, branch, regwrite, aluop, illegal_op};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit supported(input logic [5:0] o);
    return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
           (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
  endfunction

  // Number of cycles the instruction occupies.
  function automatic int seq_len(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return 4;
      6'b001000: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      default:   return 2;
    endcase
  endfunction

  // State number at position p of the instruction's sequence.
  function automatic int seq_at(input logic [5:0] o, input int p);
    if (p == 0) return 0;
    if (p == 1) return 1;
    case (o)
      6'b100011: return (p == 2) ? 2 : (p == 3) ? 3 : 4;
      6'b101011: return (p == 2) ? 2 : 5;
      6'b000000: return (p == 2) ? 6 : 7;
      6'b001000: return (p == 2) ? 9 : 10;
      6'b000100: return 8;
      6'b000010: return 11;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [15:0] exp_vec(input int s, input logic [5:0] o, input logic rn);
    logic m2r, rd, io, asa, irw, mw, pcw, br, rw, ill;
    logic [1:0] ps, asb, ao;
    {m2r, rd, io, asa, irw, mw, pcw, br, rw, ill} = '0;
    ps = 2'b00; asb = 2'b00; ao = 2'b00;
    case (s)
      0:  begin asb = 2'b01; irw = 1; pcw = 1; end
      1:  begin asb = 2'b11; ill = !supported(o); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; ao = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (!rn) {irw, mw, pcw, br, rw, ill} = '0;
    return {m2r, rd, io, ps, asb, asa, irw, mw, pcw, br, rw, ao, ill};
  endfunction

  int          mpos = 0;
  logic [5:0]  mop = 6'b0;
  bit          mvalid = 0;
  int          mstate;
  assign mstate = seq_at(mop, mpos);

  always @(posedge clk) begin
    if (!rst_n) begin
      mpos   <= 0;
      mvalid <= 1;
    end else if (mvalid) begin
      if (mpos == 0) mpos <= 1;
      else if (mpos == 1) begin
        mop  <= op;
        mpos <= supported(op) ? 2 : 0;
      end else if (mpos + 1 >= seq_len(mop)) mpos <= 0;
      else mpos <= mpos + 1;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("state", {28'b0, state}, mstate);
      chk("outputs", {16'b0, act_vec}, {16'b0, exp_vec(mstate, op, rst_n)});
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] trace;
  logic [15:0] vtrace[$];
  bit          rw_seen;

  // Runs one instruction starting in FETCH; optionally pulls reset low
  // once the instruction has entered its abort_at-th state.
  task automatic do_instr(input logic [5:0] o, input int abort_at);
    int step = 0;
    bit done = 0;
    op = o;
    trace = 0;
    vtrace.delete();
    rw_seen = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      trace = (trace << 4) | {28'b0, state};
      vtrace.push_back(act_vec);
      if (regwrite) rw_seen = 1;
      @(posedge clk);
      #1;
      step++;
      if (mpos == 0) done = 1;
      else if (step == abort_at) rst_n = 0;
    end
    if (!done) chk("instr_timeout", 0, 1);
    rst_n = 1;
  endtask

  initial begin
    logic [5:0] ops[6];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    rst_n = 0;
    op = 6'b100011;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {28'b0, state}, 0);
    chk("reset_wen", {26'b0, pcwrite, irwrite, memwrite, regwrite, branch, illegal_op}, 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    do_instr(6'b100011, -1);
    chk("lw_trace", trace, 32'h01234);
    chk("release_fetch", {16'b0, vtrace[0]}, 32'h02A0);
    chk("lw_decode", {16'b0, vtrace[1]}, 32'h0600);
    chk("lw_memwb", {16'b0, vtrace[4]}, 32'h8008);

    do_instr(6'b101011, -1);
    chk("sw_trace", trace, 32'h0125);
    chk("sw_memwrite", {16'b0, vtrace[3]}, 32'h2040);
    chk("sw_no_regwrite", {31'b0, rw_seen}, 0);

    do_instr(6'b000000, -1);
    chk("rtype_trace", trace, 32'h0167);
    chk("rtype_exec", {16'b0, vtrace[2]}, 32'h0104);
    chk("rtype_wb", {16'b0, vtrace[3]}, 32'h4008);
    do_instr(6'b001000, -1);
    chk("addi_trace", trace, 32'h019A);
    chk("addi_exec", {16'b0, vtrace[2]}, 32'h0500);
    chk("addi_wb", {16'b0, vtrace[3]}, 32'h0008);

    do_instr(6'b000100, -1);
    chk("beq_trace", trace, 32'h018);
    chk("beq_branch", {16'b0, vtrace[2]}, 32'h0912);
    do_instr(6'b000010, -1);
    chk("j_trace", trace, 32'h01B);
    chk("j_jump", {16'b0, vtrace[2]}, 32'h1020);

    do_instr(6'b111111, -1);
    chk("illegal_trace", trace, 32'h01);
    chk("illegal_decode", {16'b0, vtrace[1]}, 32'h0601);
    chk("illegal_fetch", {31'b0, vtrace[0][0]}, 0);

    do_instr(6'b100011, 3);
    chk("abort_trace", trace, 32'h0123);
    chk("abort_memread", {16'b0, vtrace[3]}, 32'h2000);
    chk("abort_no_regwrite", {31'b0, rw_seen}, 0);
    chk("abort_state", {28'b0, state}, 0);

    for (int n = 0; n < 400; n++) begin
      logic [5:0] o;
      int ab;
      if ($urandom_range(0, 9) < 8) o = ops[$urandom_range(0, 5)];
      else o = 6'($urandom_range(0, 63));
      ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 4)) : -1;
      do_instr(o, ab);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
